// File: rtl/turn_signal_ctrl_if.sv
// Turn-signal controller port bundle: raw lever/hazard contacts in, blinker control out.
interface turn_signal_ctrl_if;
   logic       turn_left_sw;
   logic       turn_right_sw;
   logic       hazard_btn;
   logic [1:0] mode;
   logic       tick;
   logic       restart;
   logic       hazard_on;

   modport master (
      output turn_left_sw, turn_right_sw, hazard_btn,
      input  mode, tick, restart, hazard_on
   );

   modport slave (
      input  turn_left_sw, turn_right_sw, hazard_btn,
      output mode, tick, restart, hazard_on
   );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn-signal controller: synchronizes and debounces the lever/hazard contacts,
// selects the blink mode and paces the downstream blinker with a step tick.
//
// state  | meaning
// OFF    | no lamp activity, tick counter held at 0
// LEFT   | left lever only, blinking left
// RIGHT  | right lever only, blinking right
// HAZARD | hazard toggled on, overrides levers
module turn_signal_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 12500000
) (
   input  logic               clock,
   input  logic               reset,
   turn_signal_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {OFF = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, HAZARD = 2'd3} mode_t;

   localparam int DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

   // bit 0 left, bit 1 right, bit 2 hazard
   logic [2:0]     raw, sync1, sync2, deb;
   logic [DCW-1:0] db_cnt [3];
   logic           hz_prev, hazard_on_q;
   mode_t          mode_q, mode_d, mode_prev;
   logic [TCW-1:0] tick_cnt;
   logic           tick_q, restart_q;

   assign raw = {bus.hazard_btn, bus.turn_right_sw, bus.turn_left_sw};

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DCW'(1);
            end
         end
      end
   end

   // Only the press edge toggles; release and a held press are ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         hz_prev     <= 1'b0;
         hazard_on_q <= 1'b0;
      end else begin
         hz_prev <= deb[2];
         if (deb[2] && !hz_prev) hazard_on_q <= ~hazard_on_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) mode_q <= OFF;
      else       mode_q <= mode_d;
   end

   always_comb begin
      mode_d = OFF;
      if (hazard_on_q) begin
         mode_d = HAZARD;
      end else begin
         case (deb[1:0])
            2'b01:   mode_d = LEFT;
            2'b10:   mode_d = RIGHT;
            default: mode_d = OFF;
         endcase
      end
   end

   // A mode change clears the period so the new mode gets a full first step.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_prev <= OFF;
         restart_q <= 1'b0;
         tick_cnt  <= '0;
         tick_q    <= 1'b0;
      end else begin
         mode_prev <= mode_q;
         restart_q <= (mode_q != mode_prev);
         if ((mode_d != mode_q) || (mode_q == OFF)) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
         end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            tick_q   <= 1'b1;
         end else begin
            tick_cnt <= tick_cnt + TCW'(1);
            tick_q   <= 1'b0;
         end
      end
   end

   assign bus.mode      = mode_q;
   assign bus.tick      = tick_q;
   assign bus.restart   = restart_q;
   assign bus.hazard_on = hazard_on_q;
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8.
module tb_turn_signal_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   turn_signal_ctrl_if bus ();

   turn_signal_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic inputs(input logic l, input logic r, input logic h);
      bus.turn_left_sw  = l;
      bus.turn_right_sw = r;
      bus.hazard_btn    = h;
   endtask

   task automatic test_reset();
      inputs(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      step();
      n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got %0d want 0", bus.mode); end
      n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", bus.tick); end
      n_cmp++; if (bus.restart !== 1'b0) begin n_err++; $display("FAIL reset_restart got %b want 0", bus.restart); end
      n_cmp++; if (bus.hazard_on !== 1'b0) begin n_err++; $display("FAIL reset_hazard_on got %b want 0", bus.hazard_on); end
      reset = 1'b0;
      step();
      n_cmp++; if (bus.restart !== 1'b0) begin n_err++; $display("FAIL reset_release_restart got %b want 0", bus.restart); end
   endtask

   task automatic test_left();
      inputs(1'b0, 1'b0, 1'b0);
      do_reset();
      bus.turn_left_sw = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL left_latency edge %0d mode got %0d want 0", e, bus.mode); end
      end
      step();
      n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL left_mode edge 7 got %0d want 1", bus.mode); end
      n_cmp++; if (bus.restart !== 1'b0) begin n_err++; $display("FAIL left_restart_early got %b want 0", bus.restart); end
      for (int k = 1; k <= 24; k++) begin
         step();
         n_cmp++; if (bus.restart !== (k == 1)) begin n_err++; $display("FAIL left_restart k=%0d got %b want %b", k, bus.restart, (k == 1)); end
         n_cmp++; if (bus.tick !== (k % 8 == 0)) begin n_err++; $display("FAIL left_tick k=%0d got %b want %b", k, bus.tick, (k % 8 == 0)); end
      end
   endtask

   task automatic test_glitch();
      inputs(1'b0, 1'b0, 1'b0);
      do_reset();
      bus.turn_right_sw = 1'b1;
      step(); step(); step();
      bus.turn_right_sw = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         step();
         n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL glitch_mode e=%0d got %0d want 0", e, bus.mode); end
         n_cmp++; if ({bus.restart, bus.tick} !== 2'b00) begin n_err++; $display("FAIL glitch_pulses e=%0d restart/tick got %b%b want 00", e, bus.restart, bus.tick); end
      end
   endtask

   task automatic test_hazard();
      int rs;
      logic [1:0] exp_mode;
      inputs(1'b0, 1'b0, 1'b0);
      do_reset();
      bus.turn_left_sw = 1'b1;
      repeat (10) step();
      n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL hazard_pre_mode got %0d want 1", bus.mode); end
      bus.hazard_btn = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step();
         if (e == 6) bus.hazard_btn = 1'b0;
         exp_mode = (e >= 8) ? 2'd3 : 2'd1;
         n_cmp++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL hazard1_mode e=%0d got %0d want %0d", e, bus.mode, exp_mode); end
         n_cmp++; if (bus.hazard_on !== (e >= 7)) begin n_err++; $display("FAIL hazard1_on e=%0d got %b want %b", e, bus.hazard_on, (e >= 7)); end
         n_cmp++; if (bus.restart !== (e == 9)) begin n_err++; $display("FAIL hazard1_restart e=%0d got %b want %b", e, bus.restart, (e == 9)); end
         if (e >= 8) begin
            n_cmp++; if (bus.tick !== (e > 8 && (e - 8) % 8 == 0)) begin n_err++; $display("FAIL hazard1_tick e=%0d got %b want %b", e, bus.tick, (e > 8 && (e - 8) % 8 == 0)); end
         end
      end
      rs = 0;
      bus.hazard_btn = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step();
         if (bus.restart) rs++;
         if (e == 8) begin
            n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL hazard2_mode got %0d want 1", bus.mode); end
         end
      end
      n_cmp++; if (rs !== 1) begin n_err++; $display("FAIL hazard2_restarts got %0d want 1", rs); end
      n_cmp++; if (bus.hazard_on !== 1'b0) begin n_err++; $display("FAIL hazard2_held_on got %b want 0", bus.hazard_on); end
      rs = 0;
      bus.hazard_btn = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         step();
         if (bus.restart) rs++;
      end
      n_cmp++; if (rs !== 0) begin n_err++; $display("FAIL hazard_release_restarts got %0d want 0", rs); end
      n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL hazard_release_mode got %0d want 1", bus.mode); end
   endtask

   task automatic test_both_and_swap();
      int rs;
      logic [1:0] exp_mode;
      inputs(1'b0, 1'b0, 1'b0);
      do_reset();
      inputs(1'b1, 1'b1, 1'b0);
      for (int e = 1; e <= 20; e++) begin
         step();
         n_cmp++; if ({bus.mode, bus.tick, bus.restart} !== 4'b0000) begin n_err++; $display("FAIL both_idle e=%0d mode/tick/restart got %0d/%b/%b want 0/0/0", e, bus.mode, bus.tick, bus.restart); end
      end
      bus.turn_right_sw = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step();
         exp_mode = (e >= 7) ? 2'd1 : 2'd0;
         n_cmp++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL drop_right_mode e=%0d got %0d want %0d", e, bus.mode, exp_mode); end
         n_cmp++; if (bus.restart !== (e == 8)) begin n_err++; $display("FAIL drop_right_restart e=%0d got %b want %b", e, bus.restart, (e == 8)); end
      end
      repeat (10) step();
      rs = 0;
      inputs(1'b0, 1'b1, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         step();
         if (bus.restart) rs++;
         exp_mode = (e >= 7) ? 2'd2 : 2'd1;
         n_cmp++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL swap_mode e=%0d got %0d want %0d", e, bus.mode, exp_mode); end
      end
      n_cmp++; if (rs !== 1) begin n_err++; $display("FAIL swap_restarts got %0d want 1", rs); end
   endtask

   task automatic test_reset_mid();
      inputs(1'b0, 1'b0, 1'b0);
      do_reset();
      bus.hazard_btn = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step();
         if (e == 6) bus.hazard_btn = 1'b0;
      end
      n_cmp++; if (bus.mode !== 2'd3) begin n_err++; $display("FAIL midreset_pre_mode got %0d want 3", bus.mode); end
      reset = 1'b1;
      step();
      n_cmp++; if ({bus.mode, bus.tick, bus.restart, bus.hazard_on} !== 5'b0) begin n_err++; $display("FAIL midreset_outputs mode/tick/restart/hz got %0d/%b/%b/%b want 0/0/0/0", bus.mode, bus.tick, bus.restart, bus.hazard_on); end
      reset = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();
         n_cmp++; if ({bus.mode, bus.tick, bus.restart, bus.hazard_on} !== 5'b0) begin n_err++; $display("FAIL midreset_after e=%0d mode/tick/restart/hz got %0d/%b/%b/%b want 0/0/0/0", e, bus.mode, bus.tick, bus.restart, bus.hazard_on); end
      end
   endtask

   task automatic test_held_through_reset();
      logic [1:0] exp_mode;
      inputs(1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      step(); step(); step();
      reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         exp_mode = (e == 7) ? 2'd1 : 2'd0;
         n_cmp++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL held_reset_mode e=%0d got %0d want %0d", e, bus.mode, exp_mode); end
      end
   endtask

   initial begin
      inputs(1'b0, 1'b0, 1'b0);
      test_reset();
      test_left();
      test_glitch();
      test_hazard();
      test_both_and_swap();
      test_reset_mid();
      test_held_through_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
